// File: rtl/add_norm_round_f.sv
// add_norm_round_f: normalise, round-to-nearest-even and pack per-lane add/sub results into binary32.
// Two-stage pipeline (S1 normalise, S2 round/pack) with valid/ready handshake on both sides.
`default_nettype none

module add_norm_round_f #(
   parameter int LANES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [36*LANES-1:0]   din,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [32*LANES-1:0]   dout,
   output logic [2*LANES-1:0]    flags
);

   // S1 lane payload: {special, ovf, sign, exp[8:0], mant[23:0], guard, sticky}
   localparam int NW = 38;

   logic                  s1_valid;
   logic [NW*LANES-1:0]   s1_data;
   logic [NW*LANES-1:0]   norm_d;
   logic [32*LANES-1:0]   pack_d;
   logic [2*LANES-1:0]    pack_f;
   logic                  s2_free;

   assign s2_free  = !out_valid | out_ready;
   assign in_ready = !s1_valid | s2_free;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [35:0] v;
      logic [7:0]  ee;
      logic [4:0]  lz;
      logic [7:0]  k;
      logic [25:0] t;
      logic [8:0]  nexp;
      logic [23:0] nmant;
      logic        ng;
      logic        ns;

      assign v = din[36*l +: 36];

      always_comb begin
         ee = (v[34:27] == 8'd0) ? 8'd1 : v[34:27];
         lz = 5'd26;
         for (int i = 0; i < 26; i++) begin
            if (v[i]) lz = 5'(25 - i);
         end
         // Shift is capped so the exponent never drops below 1; anything left unnormalised is denormal.
         k = ({3'b0, lz} < (ee - 8'd1)) ? {3'b0, lz} : (ee - 8'd1);
         t = v[25:0] << k;
         if (v[26]) begin
            nmant = v[26:3];
            ng    = v[2];
            ns    = v[1] | v[0];
            nexp  = {1'b0, ee} + 9'd1;
         end else begin
            nmant = t[25:2];
            ng    = t[1];
            ns    = t[0];
            nexp  = t[25] ? ({1'b0, ee} - {1'b0, k}) : 9'd0;
         end
      end

      assign norm_d[NW*l +: NW] = {(v[34:27] == 8'hFF), (nexp >= 9'd255), v[35], nexp, nmant, ng, ns};

      logic [NW-1:0] q;
      logic          inc;
      logic [24:0]   sum;
      logic [8:0]    rexp;
      logic [31:0]   pk;
      logic [1:0]    pf;

      assign q = s1_data[NW*l +: NW];

      always_comb begin
         inc  = q[1] & (q[0] | q[2]);
         sum  = {1'b0, q[25:2]} + {24'd0, inc};
         rexp = q[34:26] + {8'd0, sum[24]};
         // A denormal that rounds up into the hidden bit becomes the smallest normal.
         if (q[34:26] == 9'd0 && sum[23]) rexp = 9'd1;
         if (q[37]) begin
            pk = {q[35], 8'hFF, 23'h0};
            pf = 2'b00;
         end else if (q[36] || rexp >= 9'd255) begin
            pk = {q[35], 8'hFF, 23'h0};
            pf = 2'b11;
         end else begin
            pk = {q[35], rexp[7:0], sum[22:0]};
            pf = {1'b0, q[1] | q[0]};
         end
      end

      assign pack_d[32*l +: 32] = pk;
      assign pack_f[2*l +: 2]   = pf;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         out_valid <= 1'b0;
         dout      <= '0;
         flags     <= '0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) s1_data <= norm_d;
         end
         if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               dout  <= pack_d;
               flags <= pack_f;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_add_norm_round_f.sv
// Directed self-checking bench for add_norm_round_f (LANES=2).
`default_nettype none

module tb_add_norm_round_f;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [71:0] din;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] dout;
   logic [3:0]  flags;

   int n_checks = 0;
   int n_fail   = 0;

   add_norm_round_f #(.LANES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One vector through an idle pipe: out_valid must be low one cycle after the transfer and high the next.
   task automatic send(input string tag, input logic [35:0] l0, input logic [35:0] l1,
                       input logic [63:0] exp_d, input logic [3:0] exp_f);
      din       = {l1, l0};
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_dout"}, dout, exp_d);
      chk({tag, "_flags"}, {60'd0, flags}, {60'd0, exp_f});
      @(negedge clk);
   endtask

   localparam logic [35:0] L1V = {1'b1, 8'h7F, 27'h4000000};   // -2.0 on lane 1
   localparam logic [31:0] L1R = 32'hC0000000;

   logic [35:0] bp_in  [4];
   logic [31:0] bp_exp [4];
   logic [63:0] held;

   initial begin
      int idx;
      int got;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      din       = '0;
      #12;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_dout", dout, 64'd0);
      chk("rst_flags", {60'd0, flags}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      send("one_plus_one", {1'b0, 8'h7F, 27'h4000000}, L1V, {L1R, 32'h40000000}, 4'b0000);
      send("cancel",       {1'b0, 8'h7F, 27'h0800000}, L1V, {L1R, 32'h3E800000}, 4'b0000);
      send("zero",         {1'b0, 8'h00, 27'h0000000}, L1V, {L1R, 32'h00000000}, 4'b0000);
      send("denorm",       {1'b0, 8'h00, 27'h1000000}, L1V, {L1R, 32'h00400000}, 4'b0000);
      send("tie_even",     {1'b0, 8'h7F, 27'h2000002}, L1V, {L1R, 32'h3F800000}, 4'b0001);
      send("round_up",     {1'b0, 8'h7F, 27'h2000006}, L1V, {L1R, 32'h3F800002}, 4'b0001);
      send("mant_carry",   {1'b0, 8'h7F, 27'h3FFFFFE}, L1V, {L1R, 32'h40000000}, 4'b0001);
      send("ovf_norm",     {1'b1, 8'hFE, 27'h4000000}, L1V, {L1R, 32'hFF800000}, 4'b0011);
      send("ovf_lane1",    L1V, {1'b0, 8'hFE, 27'h3FFFFFE}, {32'h7F800000, L1R}, 4'b1100);
      send("special_inf",  {1'b0, 8'hFF, 27'h1234567}, L1V, {L1R, 32'h7F800000}, 4'b0000);
      send("denorm_to_norm", {1'b0, 8'h00, 27'h1FFFFFE}, L1V, {L1R, 32'h00800000}, 4'b0001);

      // Backpressure: four back-to-back vectors, consumer stalled for the first three cycles.
      bp_in[0] = {1'b0, 8'h7F, 27'h4000000}; bp_exp[0] = 32'h40000000;
      bp_in[1] = {1'b0, 8'h7F, 27'h0800000}; bp_exp[1] = 32'h3E800000;
      bp_in[2] = {1'b0, 8'h7F, 27'h2000006}; bp_exp[2] = 32'h3F800002;
      bp_in[3] = {1'b0, 8'h00, 27'h1000000}; bp_exp[3] = 32'h00400000;
      idx  = 0;
      got  = 0;
      held = '0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         in_valid  = (idx < 4);
         din       = {L1V, bp_in[(idx < 4) ? idx : 3]};
         out_ready = (cyc >= 3);
         #1;
         if (cyc == 2) begin
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            chk("bp_first_out", dout, {L1R, bp_exp[0]});
            held = dout;
         end
         if (cyc == 3) chk("bp_dout_held", dout, held);
         if (out_valid && out_ready) begin
            chk("bp_order", dout, {L1R, bp_exp[(got < 4) ? got : 3]});
            got++;
         end
         if (in_valid && in_ready) idx++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("bp_accepted", 64'(idx), 64'd4);
      chk("bp_delivered", 64'(got), 64'd4);

      // Reset with data in flight.
      din       = {L1V, bp_in[0]};
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      got       = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         if (out_valid) got++;
      end
      chk("no_stale_out", 64'(got), 64'd0);
      chk("post_rst_dout", dout, 64'd0);
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/add_norm_round_f.md
Name: add_norm_round_f

Overview:
- Downstream stage of the dual-lane single-precision add/sub datapath.
- Consumes the un-normalised per-lane result: sign, raw exponent, and 27-bit magnitude carrying a carry bit, a hidden bit, guard and sticky.
- Normalises, rounds to nearest-even and packs each lane into IEEE-754 binary32.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- LANES, 2, number of independent 36-bit lanes processed in parallel.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  din holds a valid result vector.
- in_ready  output  1  stage accepts din this cycle.
- din  input  36*LANES  per lane L at [36L+35:36L], as follows:
  - [35] sign.
  - [34:27] exponent field E (0 means denormal/zero).
  - [26:0] magnitude m: [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] sticky.
- out_valid  output  1  dout/flags valid.
- out_ready  input  1  consumer takes dout this cycle.
- dout  output  32*LANES  packed binary32 per lane at [32L+31:32L].
- flags  output  2*LANES  per lane {overflow, inexact} at [2L+1:2L].

Behaviour:
- Reset: out_valid=0, dout=0, flags=0, internal valid bits cleared, pipeline contents discarded. in_ready=1 once reset is released.
- Transfer rules:
  - A transfer occurs when valid&ready are both high at a rising clk edge.
  - Latency is 2 cycles from in-transfer to out_valid with no stall.
  - Throughput is 1 per cycle.
- Stages:
  - S1 register: normalise.
  - S2 register: round and pack.
- Stalls:
  - in_ready = !s1_valid | (!s2_valid | out_ready).
  - Stages advance only when the downstream slot is free or draining.
  - dout/flags are held stable while out_valid & !out_ready.
  - Order is preserved, with no drop or duplication.
- Effective exponent Ee = (E==0) ? 1 : E.
- Normalise (S1), per lane:
  - m[26]=1: mantissa = m[26:3], g = m[2], s = m[1]|m[0], exponent Ee+1.
  - else:
    - lz = leading zeros of m[25:0] counted from bit 25 (0..26).
    - shift k = min(lz, Ee-1).
    - t = m<<k; mantissa = t[25:2], g = t[1], s = t[0]; exponent Ee-k.
    - If t[25]=0, exponent field = 0 (denormal result).
  - m==0: exact zero; output {sign, 31'h0}, flags 0.
- Round (S2):
  - inc = g & (s | mantissa[0]); mantissa24 + inc.
  - Carry out of bit 23 on a normal result: exponent+1, mantissa = 24'h800000.
  - Denormal that rounds to bit23 set: exponent field becomes 1.
  - inexact = g|s.
- Overflow: exponent ≥ 255 after normalise or round gives {sign, 8'hFF, 23'h0}, overflow=1, inexact=1.
- Special input: E==8'hFF passes as {sign, 8'hFF, 23'h0}, flags 0.
- Lanes are fully independent and share one handshake.
- Reset mid-operation discards all in-flight data. No output is produced for items accepted before reset.

Test Plan:
- Lane0 din={0,8'h7F,27'h4000000} (1.0+1.0) -> lane0 dout 32'h40000000, flags 2'b00, out_valid exactly 2 cycles after transfer.
- Cancellation {0,8'h7F,27'h0800000} -> 32'h3E800000 (0.25, lz=2), flags 00.
- Zero and denormal:
  - {0,8'h00,27'h0} -> 32'h00000000, flags 00.
  - {0,8'h00,27'h1000000} -> 32'h00400000, flags 00.
- Rounding:
  - {0,8'h7F,27'h2000002} (tie, even lsb) -> 32'h3F800000, inexact=1.
  - {0,8'h7F,27'h2000006} -> 32'h3F800002, inexact=1.
  - {0,8'h7F,27'h3FFFFFE} -> mantissa carry -> 32'h40000000, inexact=1.
- Overflow {1,8'hFE,27'h4000000} -> 32'hFF800000, flags 2'b11; other lane unaffected.
- Backpressure:
  - Stimulus: stream 4 vectors back-to-back, out_ready=0 for 3 cycles, then 1.
  - in_ready drops after 2 vectors are accepted.
  - dout is held stable while stalled.
  - All 4 results emerge in order with no loss.
  - Assert rst mid-stream: out_valid=0 next cycle asynchronously, no stale output after release.
